twiddle_addr_gen: RTL and testbench
===================================

Name: twiddle_addr_gen

Overview:
- Sequential, parametrised twiddle-ROM address generator for the radix-2 DIF FFT datapath.
- Replaces the fixed 16-point combinational twiddle address mapper.
- Started once per stage, it walks all N/2 butterflies of that stage and emits one twiddle address per butterfly over a valid/ready stream to the twiddle ROM and butterfly scheduler.
- Supports any power-of-two N and any stage.

Parameters:
- LOG2N, 5, log2 of FFT size N (N=32 default); legal range 3..12.
- STG_W, 4, width of the stage input; must satisfy 2^STG_W > LOG2N.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request to generate one stage; accepted only when busy=0.
- stage  input  STG_W  stage number, sampled on accepted start.
- busy  output  1  high from accepted start until the last address is accepted.
- out_valid  output  1  tw_addr/bfly_idx/last are valid.
- out_ready  input  1  downstream accepts the current output when high with out_valid.
- tw_addr  output  LOG2N-1  twiddle ROM address (LOG2N-2 when TWADDR_QUARTER_EN is defined).
- bfly_idx  output  LOG2N-1  butterfly index k of the current output.
- last  output  1  current output is butterfly k=N/2-1.
- done  output  1  single-cycle pulse after the last handshake.

Behaviour:
- FSM states:
  - IDLE: busy=0, out_valid=0.
  - RUN: busy=1, out_valid=1.
- Transitions:
  - IDLE -> RUN on start=1. stage is latched into stg_q; k is set to 0.
  - RUN -> IDLE on (out_valid & out_ready & last). done=1 on the following cycle only.
- Latency: start at edge t gives out_valid=1 with k=0 after edge t (first cycle after acceptance). No bubbles while out_ready is held high: one address per cycle, N/2 cycles per stage.
- Address rule for stage s < LOG2N:
  - group half-size H = N>>(s+1).
  - j = k mod H.
  - tw_addr = j << s, truncated to LOG2N-1 bits. Range is 0..N/2-1.
  - Stage LOG2N-1 gives tw_addr=0 for all k.
- stage >= LOG2N: the sequence still runs all N/2 butterflies, with tw_addr=0 throughout.
- Stall: when out_valid=1 and out_ready=0, tw_addr, bfly_idx and last hold stable and k does not advance.
- All outputs are registered; there is no combinational path from out_ready to out_valid.
- Start while busy=1 is ignored, with no effect on the stage in progress or on the latched stage.
- Start in the same cycle that done is high is accepted normally, since the FSM is already in IDLE.
- Reset (any time, including mid-stage): next edge forces IDLE.
  - busy=0, out_valid=0, done=0, last=0, tw_addr=0, bfly_idx=0, k=0, stg_q=0.
  - Any partial stage is abandoned.
- k is a LOG2N-1-bit counter. It is never allowed to wrap; last is what terminates the stage.

Optional Feature:
- Macro TWADDR_QUARTER_EN, for a quarter-wave twiddle ROM.
- Defined:
  - tw_addr width becomes LOG2N-2.
  - Adds output port tw_swap (1 bit, registered, reset 0).
  - For full address a computed as above:
    - a < N/4: tw_addr = a, tw_swap = 0.
    - otherwise: tw_addr = a - N/4, tw_swap = 1. The butterfly applies W^(a) = -j * W^(a-N/4).
  - tw_swap holds with tw_addr during a stall.
- Undefined: full-range tw_addr, no tw_swap port.

Test Plan (LOG2N=5, out_ready=1 unless stated):
- Stage 0: pulse start with stage=0. Response:
  - out_valid rises 1 cycle later.
  - tw_addr = 0,1,...,15 on consecutive cycles; last with 15.
  - done pulse the next cycle; busy low again.
- Stage 1: tw_addr = 0,2,4,...,14,0,2,...,14.
- Stage 2: tw_addr = 0,4,8,12 repeated 4 times.
- Stages 4 and 7: 16 outputs, all tw_addr=0; last and done as normal.
- Stall: stage=0, out_ready=0 for 3 cycles when bfly_idx=5. tw_addr=5 is held for 4 cycles, then the sequence continues 6..15. start=1 with stage=2 at bfly_idx=8 is ignored.
- Reset mid-stage: rst=1 at bfly_idx=9 gives out_valid=0, busy=0, tw_addr=0 after the edge and no done pulse. A new start with stage=1 then yields 0,2,...
- With TWADDR_QUARTER_EN, stage=0:
  - k=3: tw_addr=3, tw_swap=0.
  - k=10: tw_addr=2, tw_swap=1.
  - k=15: tw_addr=7, tw_swap=1.

Source files
------------

// File: rtl/twiddle_addr_gen.sv
// -----------------------------------------------------------------------------
// twiddle_addr_gen
//
// Sequential twiddle-ROM address generator for a radix-2 DIF FFT of size
// N = 2**LOG2N. One accepted start walks all N/2 butterflies of the requested
// stage. Each butterfly produces one twiddle address on a valid/ready stream.
//
// Address rule for stage s < LOG2N, butterfly k:
//   H = N >> (s+1),  j = k mod H,  tw_addr = j << s  (0..N/2-1).
// Stages s >= LOG2N-1 produce tw_addr = 0 for every butterfly.
//
// Optional build macro TWADDR_QUARTER_EN targets a quarter-wave ROM. The
// address shrinks to LOG2N-2 bits. A tw_swap flag is added, and it is set
// whenever the full address lies in the upper quarter (a >= N/4).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request one stage; accepted only while busy=0
//   stage      in   [STG_W]   stage number, sampled on accepted start
//   busy       out  high from accepted start until last address accepted
//   out_valid  out  tw_addr/bfly_idx/last (and tw_swap) are valid
//   out_ready  in   downstream accepts current output
//   tw_addr    out  [LOG2N-1] (or [LOG2N-2] with TWADDR_QUARTER_EN)
//   bfly_idx   out  [LOG2N-1] butterfly index k of current output
//   last       out  current output is k = N/2-1
//   tw_swap    out  (TWADDR_QUARTER_EN only) use -j * W^(a-N/4)
//   done       out  one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module twiddle_addr_gen #(
    parameter int LOG2N = 5,
    parameter int STG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STG_W-1:0]   stage,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef TWADDR_QUARTER_EN
    output logic [LOG2N-3:0]   tw_addr,
    output logic               tw_swap,
`else
    output logic [LOG2N-2:0]   tw_addr,
`endif
    output logic [LOG2N-2:0]   bfly_idx,
    output logic               last,
    output logic               done
);

    localparam int K_W = LOG2N - 1;
`ifdef TWADDR_QUARTER_EN
    localparam int A_W = LOG2N - 2;
`else
    localparam int A_W = LOG2N - 1;
`endif

    localparam logic [0:0]     S_IDLE  = 1'b0;
    localparam logic [0:0]     S_RUN   = 1'b1;
    localparam logic [K_W-1:0] K_LAST  = '1;      // N/2-1
    localparam logic [31:0]    LOG2N_U = LOG2N;

    logic [0:0]       state_q;
    logic [STG_W-1:0] stg_q;
    logic [K_W-1:0]   k_q;

    logic [K_W-1:0]   k_next;
    logic [STG_W-1:0] stg_sel;
    logic [K_W-1:0]   a_next;

    // (k mod H) << s. H-1 equals (N/2-1) >> s, so the modulo is a mask.
    function automatic logic [K_W-1:0] full_addr(input logic [K_W-1:0]   k,
                                                 input logic [STG_W-1:0] s);
        logic [K_W-1:0] mask;
        if (32'(s) >= LOG2N_U) begin
            return '0;
        end
        mask = '1;
        mask = mask >> s;
        return (k & mask) << s;
    endfunction

    // The address for the next presented butterfly is computed in advance,
    // so every output is driven straight from a flop.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        k_next  = '0;
        stg_sel = stage;
        if (state_q == S_RUN) begin
            k_next  = k_q + 1'b1;
            stg_sel = stg_q;
        end
        a_next = full_addr(k_next, stg_sel);
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stg_q   <= '0;
            k_q     <= '0;
            tw_addr <= '0;
            last    <= 1'b0;
            done    <= 1'b0;
`ifdef TWADDR_QUARTER_EN
            tw_swap <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        stg_q   <= stage;
                        k_q     <= '0;
                        tw_addr <= a_next[A_W-1:0];
                        last    <= 1'b0;      // N/2 >= 4, so k=0 is never last
`ifdef TWADDR_QUARTER_EN
                        tw_swap <= a_next[K_W-1];
`endif
                    end
                end
                S_RUN: begin
                    // With out_ready low nothing moves, which holds the outputs.
                    if (out_ready) begin
                        if (last) begin
                            state_q <= S_IDLE;
                            done    <= 1'b1;
                        end else begin
                            k_q     <= k_next;
                            tw_addr <= a_next[A_W-1:0];
                            last    <= (k_next == K_LAST);
`ifdef TWADDR_QUARTER_EN
                            // The upper-quarter bit becomes the swap flag,
                            // and the lower bits are a - N/4.
                            tw_swap <= a_next[K_W-1];
`endif
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = state_q;
    assign out_valid = state_q;
    assign bfly_idx  = k_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_twiddle_addr_gen
//
// Self-checking bench for twiddle_addr_gen at LOG2N=5. Each scenario task
// pushes the expected butterfly sequence into a scoreboard queue when it
// issues start. Entries are then compared and popped as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_twiddle_addr_gen;

    localparam int LOG2N = 5;
    localparam int STG_W = 4;
    localparam int N     = 1 << LOG2N;
    localparam int HALF  = N / 2;
`ifdef TWADDR_QUARTER_EN
    localparam int A_W = LOG2N - 2;
`else
    localparam int A_W = LOG2N - 1;
`endif

    typedef struct {
        int addr;
        int idx;
        int lst;
        int swap;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [STG_W-1:0] stage;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [A_W-1:0]   tw_addr;
    logic [LOG2N-2:0] bfly_idx;
    logic             last;
    logic             done;
`ifdef TWADDR_QUARTER_EN
    logic             tw_swap;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    twiddle_addr_gen #(.LOG2N(LOG2N), .STG_W(STG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage     (stage),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tw_addr   (tw_addr),
`ifdef TWADDR_QUARTER_EN
        .tw_swap   (tw_swap),
`endif
        .bfly_idx  (bfly_idx),
        .last      (last),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: j = k mod (N >> (s+1)), a = j << s, zero for s >= LOG2N.
    function automatic exp_t model(input int k, input int s);
        exp_t e;
        int   a;
        if (s >= LOG2N) a = 0;
        else a = ((k % (N >> (s + 1))) << s) % HALF;
`ifdef TWADDR_QUARTER_EN
        e.addr = a % (N / 4);
        e.swap = (a >= N / 4) ? 1 : 0;
`else
        e.addr = a;
        e.swap = 0;
`endif
        e.idx = k;
        e.lst = (k == HALF - 1) ? 1 : 0;
        return e;
    endfunction

    // Runs one stage from the current negedge. A stall of 3 cycles is inserted
    // at butterfly stall_k, and a start is raised at butterfly ign_k (-1 = none).
    // The task returns on the negedge where done is expected high.
    task automatic do_stage(input string name, input int s, input int stall_k, input int ign_k);
        exp_t e;
        int   stall_left;
        int   cyc;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_valid: got %0b want 0", name, out_valid);
        end
        start = 1'b1;
        stage = STG_W'(s);
        for (int k = 0; k < HALF; k++) sb.push_back(model(k, s));
        @(negedge clk);
        start      = 1'b0;
        stall_left = 3;
        cyc        = 0;
        while (sb.size() > 0 && cyc < 200) begin
            cyc++;
            e = sb[0];
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s valid_busy k=%0d: got v=%0b b=%0b want 1 1",
                         name, e.idx, out_valid, busy);
            end
            n_checks++;
            if (tw_addr !== A_W'(e.addr) || int'(bfly_idx) != e.idx || int'(last) != e.lst) begin
                n_fail++;
                $display("FAIL %s output k=%0d: got addr=%0d idx=%0d last=%0b want addr=%0d idx=%0d last=%0d",
                         name, e.idx, tw_addr, bfly_idx, last, e.addr, e.idx, e.lst);
            end
`ifdef TWADDR_QUARTER_EN
            n_checks++;
            if (int'(tw_swap) != e.swap) begin
                n_fail++;
                $display("FAIL %s tw_swap k=%0d: got %0b want %0d", name, e.idx, tw_swap, e.swap);
            end
`endif
            if (e.idx == stall_k && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
                void'(sb.pop_front());
            end
            if (e.idx == ign_k && out_ready) begin
                start = 1'b1;
                stage = STG_W'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        start     = 1'b0;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL %s timeout: %0d entries left, want 0", name, sb.size());
            sb.delete();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: got done=%0b busy=%0b valid=%0b want 1 0 0",
                     name, done, busy, out_valid);
        end
    endtask

    task automatic expect_done_low(input string name);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: got done=%0b busy=%0b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        stage     = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || last !== 1'b0 ||
            tw_addr !== '0 || bfly_idx !== '0) begin
            n_fail++;
            $display("FAIL reset: got busy=%0b valid=%0b done=%0b last=%0b addr=%0d idx=%0d want all 0",
                     busy, out_valid, done, last, tw_addr, bfly_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stages();
        do_stage("stage0", 0, -1, -1);
        expect_done_low("stage0");
        do_stage("stage1", 1, -1, -1);
        expect_done_low("stage1");
        do_stage("stage2", 2, -1, -1);
        expect_done_low("stage2");
        do_stage("stage4", 4, -1, -1);
        expect_done_low("stage4");
        do_stage("stage7", 7, -1, -1);
        expect_done_low("stage7");
    endtask

    task automatic test_stall_ignore();
        do_stage("stall", 0, 5, 8);
        expect_done_low("stall");
    endtask

    task automatic test_back_to_back();
        do_stage("b2b_a", 3, -1, -1);
        // Start raised on the cycle done is high must be accepted.
        do_stage("b2b_b", 1, -1, -1);
        expect_done_low("b2b_b");
    endtask

    task automatic test_reset_mid();
        int cyc;
        start = 1'b1;
        stage = '0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(out_valid === 1'b1 && int'(bfly_idx) == 9) && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (cyc >= 50) begin
            n_fail++;
            $display("FAIL reset_mid reach: got idx=%0d want 9", bfly_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || tw_addr !== '0 || bfly_idx !== '0 ||
            last !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid state: got valid=%0b busy=%0b addr=%0d idx=%0d last=%0b done=%0b want all 0",
                     out_valid, busy, tw_addr, bfly_idx, last, done);
        end
        expect_done_low("reset_mid");
        do_stage("after_reset", 1, -1, -1);
        expect_done_low("after_reset");
    endtask

    initial begin
        test_reset();
        test_stages();
        test_stall_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
